// File: rtl/cart_bank_mapper.sv
// cart_bank_mapper: runtime-loaded cartridge ROM with Atari plain/F8/F6/F4
// bank switching; holds the CPU in reset while an image is loaded.
// Optional macro CART_SUPERCHIP_EN adds the 128-byte "SC" RAM at 1000-10FF.
// Ports:
//   clk_i, nreset           clock, async active-low reset
//   cpu_en/addr/rw/din      6502 bus cycle (sampled when cpu_en=1)
//   cart_dout, cart_sel     read data and A12 select, 1-cycle latency
//   ld_start/mode/we/addr/data/done  image load port
//   cpu_rst_o, bank_o       CPU reset request, current bank
module cart_bank_mapper #(
    parameter int ROM_KB     = 32,
    parameter int REL_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        nreset,
    input  logic        cpu_en,
    input  logic [12:0] cpu_addr,
    input  logic        cpu_rw,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cart_dout,
    output logic        cart_sel,
    input  logic        ld_start,
    input  logic [1:0]  ld_mode,
    input  logic        ld_we,
    input  logic [14:0] ld_addr,
    input  logic [7:0]  ld_data,
    input  logic        ld_done,
    output logic        cpu_rst_o,
    output logic [2:0]  bank_o
);

    localparam int DEPTH = ROM_KB * 1024;
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_LOAD,
        ST_REL
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] mode_q, mode_d;
    logic [2:0] bank_q, bank_d;
    logic [7:0] cnt_q, cnt_d;

    logic        vld_q;
    logic        sel_q;
    logic [7:0]  rom_q;
    logic [7:0]  rd_data;
    logic [7:0]  rom [DEPTH];

    logic [11:0] lo;
    logic        hs_hit;
    logic [2:0]  hs_bank;
    logic [1:0]  off2;
    logic [2:0]  off3;
    logic [2:0]  top_bank;
    logic [2:0]  eff_bank;
    logic [14:0] phys_full;
    logic [AW-1:0] phys;
    logic        run;
    logic        rd_en;

    assign run   = (state_q == ST_RUN);
    assign rd_en = cpu_en & run;
    assign lo    = cpu_addr[11:0];
    assign off2  = lo[1:0] - 2'd2;
    assign off3  = lo[2:0] - 3'd4;

    // Hotspot decode; bank offsets come from the low address bits
    always_comb begin
        hs_hit  = 1'b0;
        hs_bank = 3'd0;
        case (mode_q)
            2'd1: begin
                hs_hit  = (lo == 12'hFF8) || (lo == 12'hFF9);
                hs_bank = {2'b00, lo[0]};
            end
            2'd2: begin
                hs_hit  = (lo >= 12'hFF6) && (lo <= 12'hFF9);
                hs_bank = {1'b0, off2};
            end
            2'd3: begin
                hs_hit  = (lo >= 12'hFF4) && (lo <= 12'hFFB);
                hs_bank = off3;
            end
            default: begin
                hs_hit  = 1'b0;
                hs_bank = 3'd0;
            end
        endcase
    end

    always_comb begin
        case (mode_q)
            2'd1:    top_bank = 3'd1;
            2'd2:    top_bank = 3'd3;
            2'd3:    top_bank = 3'd7;
            default: top_bank = 3'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        bank_d  = bank_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_RUN: begin
                if (ld_start) begin
                    state_d = ST_LOAD;
                    mode_d  = ld_mode;
                end else if (cpu_en && cpu_addr[12] && hs_hit) begin
                    bank_d = hs_bank;
                end
            end
            ST_LOAD: begin
                if (ld_start) begin
                    mode_d = ld_mode;
                end else if (ld_done) begin
                    state_d = ST_REL;
                    bank_d  = top_bank;
                    cnt_d   = 8'(REL_CYCLES);
                end
            end
            ST_REL: begin
                if (ld_start) begin
                    state_d = ST_LOAD;
                    mode_d  = ld_mode;
                end else if (cnt_q <= 8'd1) begin
                    state_d = ST_RUN;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_RUN;
            mode_q  <= 2'd0;
            bank_q  <= 3'd0;
            cnt_q   <= 8'd0;
            vld_q   <= 1'b0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            bank_q  <= bank_d;
            cnt_q   <= cnt_d;
            if (!run) begin
                vld_q <= 1'b0;
                sel_q <= 1'b0;
            end else if (cpu_en) begin
                vld_q <= 1'b1;
                sel_q <= cpu_addr[12];
            end
        end
    end

    // Read uses the pre-update bank, so a hotspot read sees the old bank
    assign eff_bank  = (mode_q == 2'd0) ? 3'd0 : bank_q;
    assign phys_full = {eff_bank, lo};
    assign phys      = phys_full[AW-1:0];

    always_ff @(posedge clk_i) begin
        if ((state_q == ST_LOAD) && ld_we)
            rom[ld_addr[AW-1:0]] <= ld_data;
        if (rd_en)
            rom_q <= rom[phys];
    end

`ifdef CART_SUPERCHIP_EN
    logic [7:0] ram [128];
    logic [7:0] ram_q;
    logic       ram_rd_q;
    logic       sc_wr;
    logic       sc_rd;

    assign sc_wr = rd_en & cpu_addr[12] & ~cpu_rw &
                   (cpu_addr[11:7] == 5'd0);
    assign sc_rd = rd_en & cpu_addr[12] &
                   (cpu_addr[11:7] == 5'd1);

    always_ff @(posedge clk_i) begin
        if (sc_wr)
            ram[cpu_addr[6:0]] <= cpu_din;
        if (sc_rd)
            ram_q <= ram[cpu_addr[6:0]];
    end

    always_ff @(posedge clk_i or negedge nreset) begin
        if (!nreset)
            ram_rd_q <= 1'b0;
        else if (rd_en)
            ram_rd_q <= sc_rd;
    end

    assign rd_data = ram_rd_q ? ram_q : rom_q;
`else
    assign rd_data = rom_q;
`endif

    logic unused_ok;
    assign unused_ok = ^{cpu_din, cpu_rw, ld_addr};

    assign cart_dout = (vld_q && run) ? rd_data : 8'h00;
    assign cart_sel  = sel_q;
    assign cpu_rst_o = ~run;
    assign bank_o    = bank_q;

endmodule
